// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning N-to-1 multiplexer.
// No logic; state encoding and control-input polarities only.
// Imported by the mux datapath and its control wrapper.
package mux_pkg;

  typedef enum logic [1:0] {
    DIS  = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam logic EN_ACTIVE = 1'b0;

endpackage

// File: rtl/mux_nto1.sv
// Purely combinational N-to-1 indexed mux, W bits per channel.
// Latency: zero cycles; the select is decoded in the same cycle.
// No flow control; a select of N or above drives all zeros.
module mux_nto1
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0]   i_dat,
  input  logic [SEL_W-1:0] i_sel,
  output logic [W-1:0]     o_dat
);

  // Compare against every legal index; codes with no matching channel fall through to zero.
  always_comb begin
    o_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_dat = i_dat[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// N-to-1 registered mux with manual select or auto-scan (DWELL cycles per channel).
// Latency: one cycle from input sampling to y; strobes align with y.
// No backpressure; valid/wrap are single-cycle pulses the consumer must catch.
module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   I,
  input  logic [SEL_W-1:0] S,
  input  logic             En,
  input  logic             mode,
  output logic [W-1:0]     y,
  output logic [SEL_W-1:0] sel_q,
  output logic             valid,
  output logic             wrap
);

  localparam int CNT_W = $clog2(DWELL + 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel_q;
  logic [W-1:0]     r_y;
  logic             r_valid;
  logic             r_wrap;

  logic [SEL_W-1:0] w_sel_n;
  logic [W-1:0]     w_mux_y;
  logic             w_dwell_end;
  logic             w_last_ch;
  logic             w_s_in_range;

  assign w_dwell_end = (r_cnt == CNT_W'(DWELL - 1));
  assign w_last_ch   = (r_sel_q == SEL_W'(N - 1));

  // With a power-of-two channel count every select code is a real channel.
  generate
    if (N == (1 << SEL_W)) begin : g_pow2
      assign w_s_in_range = 1'b1;
    end else begin : g_npow2
      assign w_s_in_range = (32'(S) < 32'(N));
    end
  endgenerate

  // Next operating state: disable dominates, then mode picks manual or scan.
  always_comb begin
    w_state_n = DIS;
    if (En == EN_ACTIVE) begin
      w_state_n = (mode == MODE_SCAN) ? SCAN : MAN;
    end
  end

  // Next select: manual follows S, scan steps at dwell end with explicit wrap, disable holds.
  always_comb begin
    w_sel_n = r_sel_q;
    case (w_state_n)
      MAN:  w_sel_n = S;
      SCAN: begin
        if (w_dwell_end) begin
          w_sel_n = w_last_ch ? '0 : r_sel_q + SEL_W'(1);
        end
      end
      default: w_sel_n = r_sel_q;
    endcase
  end

  mux_nto1 #(
    .N     (N),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .i_dat (I),
    .i_sel (w_sel_n),
    .o_dat (w_mux_y)
  );

  // Output, select, dwell counter and strobe registers, driven by the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= DIS;
      r_cnt   <= '0;
      r_sel_q <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      case (w_state_n)
        MAN: begin
          r_cnt  <= '0;
          r_wrap <= 1'b0;
          if (w_s_in_range) begin
            r_sel_q <= S;
            r_y     <= w_mux_y;
            r_valid <= (S != r_sel_q) || (r_state != MAN);
          end else begin
            r_y     <= '0;
            r_valid <= 1'b0;
          end
        end
        SCAN: begin
          r_sel_q <= w_sel_n;
          r_y     <= w_mux_y;
          r_cnt   <= w_dwell_end ? '0 : r_cnt + CNT_W'(1);
          r_valid <= (w_sel_n != r_sel_q) || (r_state != SCAN);
          r_wrap  <= w_dwell_end && w_last_ch;
        end
        default: begin
          r_y     <= '0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign y     = r_y;
  assign sel_q = r_sel_q;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1: an 8-channel DWELL=3 instance and a 5-channel DWELL=1 instance.
// Expected outputs are pushed to a queue per cycle and popped one edge later.
// Directed checks against literal values cover the scan, manual and disable scenarios.
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic        rst8_n, en8, mode8;
  logic [2:0]  s8;
  logic [31:0] i8;
  logic [3:0]  y8;
  logic [2:0]  sel8;
  logic        valid8, wrap8;

  // 5-channel instance
  logic        rst5_n, en5, mode5;
  logic [2:0]  s5;
  logic [19:0] i5;
  logic [3:0]  y5;
  logic [2:0]  sel5;
  logic        valid5, wrap5;

  mux_scan_nto1 #(.N(8), .W(4), .DWELL(3)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .I(i8), .S(s8), .En(en8), .mode(mode8),
    .y(y8), .sel_q(sel8), .valid(valid8), .wrap(wrap8)
  );

  mux_scan_nto1 #(.N(5), .W(4), .DWELL(1)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .I(i5), .S(s5), .En(en5), .mode(mode5),
    .y(y5), .sel_q(sel5), .valid(valid5), .wrap(wrap5)
  );

  typedef struct {
    int st;   // 0 disabled, 1 manual, 2 scan
    int sel;
    int cnt;
    int y;
    int valid;
    int wrap;
  } mst_t;

  typedef struct {
    int y;
    int sel;
    int valid;
    int wrap;
  } exp_t;

  mst_t m8, m5;
  exp_t q8[$];
  exp_t q5[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic mst_t mreset();
    mst_t r;
    r.st = 0; r.sel = 0; r.cnt = 0; r.y = 0; r.valid = 0; r.wrap = 0;
    return r;
  endfunction

  // Behavioural reference: one clock edge of the mux for channel count n and dwell d.
  function automatic mst_t mstep(mst_t m, int n, int d, bit rst_n, bit en, bit md,
                                 int s, logic [31:0] iv);
    mst_t r;
    int   nxt;
    int   sn;
    if (!rst_n) return mreset();
    r = m;
    r.valid = 0;
    r.wrap  = 0;
    nxt = en ? 0 : (md ? 2 : 1);
    if (nxt == 0) begin
      r.y   = 0;
      r.cnt = 0;
    end else if (nxt == 1) begin
      r.cnt = 0;
      if (s < n) begin
        r.sel   = s;
        r.y     = int'(iv[s*4 +: 4]);
        r.valid = ((s != m.sel) || (m.st != 1)) ? 1 : 0;
      end else begin
        r.y = 0;
      end
    end else begin
      sn = m.sel;
      if (m.cnt == d - 1) sn = (m.sel + 1) % n;
      r.sel   = sn;
      r.y     = int'(iv[sn*4 +: 4]);
      r.cnt   = (m.cnt + 1) % d;
      r.valid = ((sn != m.sel) || (m.st != 2)) ? 1 : 0;
      r.wrap  = ((m.cnt == d - 1) && (m.sel == n - 1)) ? 1 : 0;
    end
    r.st = nxt;
    return r;
  endfunction

  // One clock: predict, push, clock, then pop and compare both instances.
  task automatic tick(input int cycles = 1);
    exp_t e;
    for (int c = 0; c < cycles; c++) begin
      m8 = mstep(m8, 8, 3, rst8_n, en8, mode8, int'(s8), i8);
      e.y = m8.y; e.sel = m8.sel; e.valid = m8.valid; e.wrap = m8.wrap;
      q8.push_back(e);
      m5 = mstep(m5, 5, 1, rst5_n, en5, mode5, int'(s5), {12'h0, i5});
      e.y = m5.y; e.sel = m5.sel; e.valid = m5.valid; e.wrap = m5.wrap;
      q5.push_back(e);
      @(posedge clk);
      #1;
      e = q8.pop_front();
      chk("d8.y", y8, e.y);
      chk("d8.sel", sel8, e.sel);
      chk("d8.valid", valid8, e.valid);
      chk("d8.wrap", wrap8, e.wrap);
      e = q5.pop_front();
      chk("d5.y", y5, e.y);
      chk("d5.sel", sel5, e.sel);
      chk("d5.valid", valid5, e.valid);
      chk("d5.wrap", wrap5, e.wrap);
    end
  endtask

  initial begin
    m8 = mreset();
    m5 = mreset();
    rst8_n = 1'b0; en8 = 1'b0; mode8 = 1'b1; s8 = 3'd0; i8 = 32'h8765_4321;
    rst5_n = 1'b0; en5 = 1'b0; mode5 = 1'b1; s5 = 3'd0; i5 = 20'h54321;
    #2;

    // Reset held for two edges while enabled in scan mode
    tick(2);
    chk("rst.y", y8, 0);
    chk("rst.sel", sel8, 0);
    chk("rst.valid", valid8, 0);
    chk("rst.wrap", wrap8, 0);

    // Manual select of channel 5
    rst8_n = 1'b1; mode8 = 1'b0; s8 = 3'd5;
    tick(1);
    chk("man.y", y8, 6);
    chk("man.sel", sel8, 5);
    chk("man.valid", valid8, 1);
    tick(3);
    chk("man.hold_valid", valid8, 0);
    i8[23:20] = 4'hA;
    tick(1);
    chk("man.data_y", y8, 4'hA);
    chk("man.data_valid", valid8, 0);
    i8[23:20] = 4'h6;
    tick(1);

    // Disable and re-enable
    en8 = 1'b1;
    tick(1);
    chk("dis.y", y8, 0);
    chk("dis.sel", sel8, 5);
    chk("dis.valid", valid8, 0);
    en8 = 1'b0;
    tick(1);
    chk("reen.y", y8, 6);
    chk("reen.valid", valid8, 1);

    // Full scan cycle from channel 0 through the wrap
    s8 = 3'd0;
    tick(1);
    mode8 = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick(1);
      chk("scan.y", y8, ((t / 3) % 8) + 1);
      chk("scan.valid", valid8, (t == 1 || t % 3 == 0) ? 1 : 0);
      chk("scan.wrap", wrap8, (t == 24) ? 1 : 0);
    end

    // Into the second dwell cycle of channel 3, then drop to manual S=7
    tick(10);
    chk("mid.sel3", sel8, 3);
    chk("mid.y3", y8, 4);
    mode8 = 1'b0; s8 = 3'd7;
    tick(1);
    chk("mid.man_y", y8, 8);
    chk("mid.man_sel", sel8, 7);

    // Reset while scanning, then restart from channel 0
    mode8 = 1'b1;
    tick(2);
    rst8_n = 1'b0;
    tick(1);
    chk("midrst.y", y8, 0);
    chk("midrst.sel", sel8, 0);
    chk("midrst.valid", valid8, 0);
    chk("midrst.wrap", wrap8, 0);
    rst8_n = 1'b1;
    tick(1);
    chk("restart.y", y8, 1);
    chk("restart.sel", sel8, 0);
    chk("restart.valid", valid8, 1);
    tick(3);

    // Five channels, one cycle per channel
    rst5_n = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      chk("n5.sel", sel5, t % 5);
      chk("n5.y", y5, (t % 5) + 1);
      chk("n5.valid", valid5, 1);
      chk("n5.wrap", wrap5, (t % 5 == 0) ? 1 : 0);
    end
    mode5 = 1'b0; s5 = 3'd2;
    tick(1);
    chk("n5.man_y", y5, 3);
    chk("n5.man_valid", valid5, 1);
    s5 = 3'd6;
    tick(1);
    chk("n5.oor_y", y5, 0);
    chk("n5.oor_sel", sel5, 2);
    chk("n5.oor_valid", valid5, 0);
    s5 = 3'd2;
    tick(1);
    chk("n5.back_y", y5, 3);
    chk("n5.back_valid", valid5, 0);

    // Randomised control and data on both instances against the reference
    for (int r = 0; r < 80; r++) begin
      en8   = ($urandom_range(0, 7) == 0);
      mode8 = $urandom_range(0, 2) != 0;
      s8    = 3'($urandom_range(0, 7));
      i8    = $urandom;
      rst8_n = ($urandom_range(0, 30) != 0);
      en5   = ($urandom_range(0, 7) == 0);
      mode5 = $urandom_range(0, 1) != 0;
      s5    = 3'($urandom_range(0, 7));
      i5    = 20'($urandom);
      rst5_n = ($urandom_range(0, 30) != 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
